// File: rtl/nios_sd_loader_bidir_pio_if.sv
// -----------------------------------------------------------------------------
// nios_sd_loader_bidir_pio_if
// Avalon-MM slave bus bundle for the bidirectional PIO.
//   address    : register word address (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (32 bits)
//   readdata   : registered read data (32 bits)
//   irq        : registered interrupt request, active high
// Modports: master (bus side, e.g. Nios II data master), slave (the PIO).
// -----------------------------------------------------------------------------
interface nios_sd_loader_bidir_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/nios_sd_loader_bidir_pio.sv
// -----------------------------------------------------------------------------
// nios_sd_loader_bidir_pio
// Parametrised bidirectional GPIO slave on Avalon-MM with per-bit direction,
// input synchroniser, edge capture and a maskable, registered interrupt.
//
// Ports:
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   avs        : Avalon-MM slave bundle (address/chipselect/write_n/writedata
//                in, readdata/irq out)
//   bidir_port : WIDTH pins, driven from data_out where data_dir is 1
//
// Register map (word address):
//   0 data (rd: synchronised pins, wr: data_out)
//   1 direction (1 = output)
//   2 irq_mask
//   3 edge_capture (write 1 to clear)
//   4 outset   (data_out |= wd)   -- only with NIOS_SD_LOADER_BIDIR_PIO_SETCLR_EN
//   5 outclear (data_out &= ~wd)  -- only with NIOS_SD_LOADER_BIDIR_PIO_SETCLR_EN
//   6,7 unmapped (and 4,5 when the macro is undefined): read 0, writes ignored
//
// Optional feature macro: NIOS_SD_LOADER_BIDIR_PIO_SETCLR_EN
// -----------------------------------------------------------------------------
module nios_sd_loader_bidir_pio #(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  nios_sd_loader_bidir_pio_if.slave   avs,
  inout  wire  [WIDTH-1:0]            bidir_port
);

  logic [WIDTH-1:0] data_out_q,  data_out_d;
  logic [WIDTH-1:0] data_dir_q,  data_dir_d;
  logic [WIDTH-1:0] irq_mask_q,  irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q,  edge_cap_d;
  logic [WIDTH-1:0] data_prev_q;
  logic [31:0]      readdata_q,  readdata_d;
  logic             irq_q,       irq_d;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

  logic [WIDTH-1:0] data_sync;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] rise, fall, edge_evt;
  logic [WIDTH-1:0] rd_word;
  logic             wr_en;

  // Only writedata[WIDTH-1:0] is meaningful; upper bits are intentionally dropped.
  logic unused_writedata;
  assign unused_writedata = ^avs.writedata;

  // Pin drive
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign bidir_port[i] = data_dir_q[i] ? data_out_q[i] : 1'bz;
  end

  assign data_sync = sync_q[SYNC_STAGES-1];
  assign wr_en     = avs.chipselect && !avs.write_n;
  assign wd        = avs.writedata[WIDTH-1:0];

  assign rise = data_sync & ~data_prev_q;
  assign fall = ~data_sync & data_prev_q;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_evt = rise;
      1:       edge_evt = fall;
      default: edge_evt = rise | fall;
    endcase
  end

  // Register writes
  always_comb begin
    data_out_d = data_out_q;
    data_dir_d = data_dir_q;
    irq_mask_d = irq_mask_q;
    clr_mask   = '0;
    if (wr_en) begin
      case (avs.address)
        3'd0: data_out_d = wd;
        3'd1: data_dir_d = wd;
        3'd2: irq_mask_d = wd;
        3'd3: clr_mask   = wd;
`ifdef NIOS_SD_LOADER_BIDIR_PIO_SETCLR_EN
        3'd4: data_out_d = data_out_q | wd;
        3'd5: data_out_d = data_out_q & ~wd;
`endif
        default: ;
      endcase
    end
    // A new event on a bit being cleared in the same cycle keeps the bit set.
    edge_cap_d = (edge_cap_q & ~clr_mask) | edge_evt;
  end

  // Read mux, registered every cycle independent of chipselect
  always_comb begin
    case (avs.address)
      3'd0:    rd_word = data_sync;
      3'd1:    rd_word = data_dir_q;
      3'd2:    rd_word = irq_mask_q;
      3'd3:    rd_word = edge_cap_q;
      default: rd_word = '0;
    endcase
    readdata_d              = '0;
    readdata_d[WIDTH-1:0]   = rd_word;
    irq_d                   = |(edge_cap_q & irq_mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q  <= '0;
      data_dir_q  <= RESET_DIR;
      irq_mask_q  <= '0;
      edge_cap_q  <= '0;
      data_prev_q <= '0;
      sync_q      <= '0;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      data_dir_q  <= data_dir_d;
      irq_mask_q  <= irq_mask_d;
      edge_cap_q  <= edge_cap_d;
      data_prev_q <= data_sync;
      sync_q[0]   <= bidir_port;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
    end
  end

  assign avs.readdata = readdata_q;
  assign avs.irq      = irq_q;

endmodule

// File: tb/tb_nios_sd_loader_bidir_pio.sv
// -----------------------------------------------------------------------------
// tb_nios_sd_loader_bidir_pio
// Directed bench for nios_sd_loader_bidir_pio. Two instances share one bus:
// u0 captures rising edges, u2 captures any edge. Each has its own pin net,
// both driven by the same bench pin driver.
// -----------------------------------------------------------------------------
module tb_nios_sd_loader_bidir_pio;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    tb_addr = '0;
  logic          tb_cs = 1'b0;
  logic          tb_wn = 1'b1;
  logic [31:0]   tb_wd = '0;
  logic [W-1:0]  tb_en = '1;
  logic [W-1:0]  tb_val = '0;
  logic [W-1:0]  exp_dout;
  wire  [W-1:0]  pins0;
  wire  [W-1:0]  pins2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  nios_sd_loader_bidir_pio_if bus0 ();
  nios_sd_loader_bidir_pio_if bus2 ();

  assign bus0.address    = tb_addr;
  assign bus0.chipselect = tb_cs;
  assign bus0.write_n    = tb_wn;
  assign bus0.writedata  = tb_wd;
  assign bus2.address    = tb_addr;
  assign bus2.chipselect = tb_cs;
  assign bus2.write_n    = tb_wn;
  assign bus2.writedata  = tb_wd;

  for (genvar i = 0; i < W; i++) begin : g_drv
    assign pins0[i] = tb_en[i] ? tb_val[i] : 1'bz;
    assign pins2[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  nios_sd_loader_bidir_pio #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_DIR(4'h0)) u0 (
    .clk(clk), .reset_n(reset_n), .avs(bus0), .bidir_port(pins0)
  );

  nios_sd_loader_bidir_pio #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(2), .RESET_DIR(4'h0)) u2 (
    .clk(clk), .reset_n(reset_n), .avs(bus2), .bidir_port(pins2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the bench always sits on the falling edge between steps.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    tb_addr = a; tb_wd = d; tb_cs = 1'b1; tb_wn = 1'b0;
    tick();
    tb_cs = 1'b0; tb_wn = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e0, input logic [31:0] e2, input string tag);
    tb_addr = a; tb_cs = 1'b1; tb_wn = 1'b1;
    tick();
    check({tag, "_u0"}, bus0.readdata, e0);
    check({tag, "_u2"}, bus2.readdata, e2);
    tb_cs = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rdata_u0", bus0.readdata, 32'h0);
    check("rst_irq_u0", {31'b0, bus0.irq}, 32'h0);
    check("rst_irq_u2", {31'b0, bus2.irq}, 32'h0);
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, 32'h0, "rst_map");

    // Input path with direction 0: pads are not driven by the DUT
    tb_val = 4'h5;
    hold(4);
    check("in_pins_u0", {28'b0, pins0}, 32'h5);
    rd(3'd0, 32'h5, 32'h5, "in_data");
    rd(3'd3, 32'h5, 32'h5, "in_cap");
    tb_val = 4'h0;
    hold(4);
    wr(3'd3, 32'hF);
    rd(3'd3, 32'h0, 32'h0, "cap_clr");

    // Output drive; bench matches the driven value until it releases the pads
    tb_val = 4'hA;
    hold(4);
    wr(3'd0, 32'hA);
    wr(3'd1, 32'hF);
    tb_en = '0;
    #1;
    check("out_pins_u0", {28'b0, pins0}, 32'hA);
    check("out_pins_u2", {28'b0, pins2}, 32'hA);
    wr(3'd3, 32'hF);
    wr(3'd0, 32'h5);
    check("out_pins5_u0", {28'b0, pins0}, 32'h5);
    rd(3'd0, 32'hA, 32'hA, "lat1");
    rd(3'd0, 32'hA, 32'hA, "lat2");
    rd(3'd0, 32'h5, 32'h5, "lat3");
    rd(3'd3, 32'h5, 32'hF, "cap_out");
    rd(3'd1, 32'hF, 32'hF, "dir_rd");
    wr(3'd3, 32'hF);

    // Set/clear (or their absence)
    wr(3'd0, 32'h3);
    wr(3'd4, 32'h4);
`ifdef NIOS_SD_LOADER_BIDIR_PIO_SETCLR_EN
    wr(3'd5, 32'h1);
    exp_dout = 4'h6;
`else
    wr(3'd5, 32'h3);
    exp_dout = 4'h3;
`endif
    check("setclr_pins", {28'b0, pins0}, {28'b0, exp_dout});
    rd(3'd4, 32'h0, 32'h0, "rd_addr4");
    rd(3'd5, 32'h0, 32'h0, "rd_addr5");
    wr(3'd6, 32'hF);
    wr(3'd7, 32'h0);
    check("unmapped_pins", {28'b0, pins0}, {28'b0, exp_dout});
    rd(3'd6, 32'h0, 32'h0, "rd_addr6");

    // Back to inputs
    tb_val = exp_dout;
    tb_en = '1;
    wr(3'd1, 32'h0);
    tb_val = 4'h0;
    hold(4);
    wr(3'd3, 32'hF);
    wr(3'd2, 32'h1);
    check("pre_edge_irq_u0", {31'b0, bus0.irq}, 32'h0);

    // Rising edge on pin0: capture after 3 cycles, irq one cycle later
    tb_addr = 3'd3; tb_cs = 1'b1; tb_wn = 1'b1;
    tb_val = 4'h1;
    hold(3);
    check("e3_cap_u0", bus0.readdata, 32'h0);
    check("e3_irq_u0", {31'b0, bus0.irq}, 32'h0);
    tick();
    check("e4_cap_u0", bus0.readdata, 32'h1);
    check("e4_irq_u0", {31'b0, bus0.irq}, 32'h1);
    check("e4_irq_u2", {31'b0, bus2.irq}, 32'h1);
    wr(3'd3, 32'h1);
    check("clr_irq_lag_u0", {31'b0, bus0.irq}, 32'h1);
    tick();
    check("clr_irq_u0", {31'b0, bus0.irq}, 32'h0);
    check("clr_irq_u2", {31'b0, bus2.irq}, 32'h0);

    // Falling edge: only the any-edge instance reacts
    tb_val = 4'h0;
    hold(4);
    check("fall_irq_u0", {31'b0, bus0.irq}, 32'h0);
    check("fall_irq_u2", {31'b0, bus2.irq}, 32'h1);
    wr(3'd3, 32'hF);
    tick();
    check("fall_clr_irq_u2", {31'b0, bus2.irq}, 32'h0);

    // Event and clear on the same bit in the same cycle: set wins
    tb_val = 4'h1;
    hold(2);
    wr(3'd3, 32'h1);
    tick();
    check("setwins_irq_u0", {31'b0, bus0.irq}, 32'h1);
    check("setwins_irq_u2", {31'b0, bus2.irq}, 32'h1);
    rd(3'd3, 32'h1, 32'h1, "setwins_cap");
    wr(3'd3, 32'hF);
    tick();
    check("sw_clr_irq_u0", {31'b0, bus0.irq}, 32'h0);

    // Toggle pin1 twice with mask 0, then unmask
    wr(3'd2, 32'h0);
    tb_val = 4'h3;
    hold(4);
    tb_val = 4'h1;
    hold(4);
    rd(3'd3, 32'h2, 32'h2, "tog_cap");
    check("tog_irq_u2", {31'b0, bus2.irq}, 32'h0);
    wr(3'd2, 32'h2);
    check("mask_lag_u2", {31'b0, bus2.irq}, 32'h0);
    tick();
    check("mask_irq_u0", {31'b0, bus0.irq}, 32'h1);
    check("mask_irq_u2", {31'b0, bus2.irq}, 32'h1);
    rd(3'd2, 32'h2, 32'h2, "mask_rd");
    wr(3'd3, 32'hF);
    tb_val = 4'h0;
    hold(4);
    rd(3'd3, 32'h0, 32'h1, "fall_cap");

    // Reset mid-operation with pin0 held high through reset
    wr(3'd2, 32'h1);
    tick();
    check("pre_rst_irq_u2", {31'b0, bus2.irq}, 32'h1);
    #2;
    reset_n = 1'b0;
    tb_val = 4'h1;
    #1;
    check("async_rst_irq_u2", {31'b0, bus2.irq}, 32'h0);
    check("async_rst_rdata_u2", bus2.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    wr(3'd2, 32'h1);
    hold(2);
    rd(3'd3, 32'h1, 32'h1, "post_rst_cap");
    check("post_rst_irq_u0", {31'b0, bus0.irq}, 32'h1);
    check("post_rst_irq_u2", {31'b0, bus2.irq}, 32'h1);
    rd(3'd1, 32'h0, 32'h0, "post_rst_dir");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/nios_sd_loader_bidir_pio.md
Name: nios_sd_loader_bidir_pio

Overview:
- Parametrised bidirectional GPIO slave on the Avalon-MM bus; successor to the fixed 4-bit SD data-line port.
- Adds per-bit direction, an input synchroniser, edge capture with a maskable interrupt, and optional atomic bit set/clear.
- Sits between the Nios II data master and the SD card pins (DAT/CMD) or other bit-banged peripherals.

Parameters:
- WIDTH, 4, number of I/O pins (1..32)
- SYNC_STAGES, 2, input synchroniser flops (2..4)
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any
- RESET_DIR, 0, reset value of the direction register (WIDTH bits; 1 = output)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  registered interrupt request, active high
- bidir_port  inout  WIDTH  pins

Behaviour:
- Clocking and reset:
  - One clock, clk. reset_n is asynchronous and active-low.
  - Reset values: readdata=0, irq=0, data_out=0, data_dir=RESET_DIR, irq_mask=0, edge_capture=0, all sync flops=0, edge-detect history flop=0.
- Pin drive: bidir_port[i] = data_dir[i] ? data_out[i] : Z.
- Input path:
  - pin -> SYNC_STAGES flops -> data_sync.
  - One further flop holds data_prev for edge detection.
  - Latency from pin change to data_sync is SYNC_STAGES cycles.
- Register map (word address):
  - 0 data: read data_sync; write data_out.
  - 1 direction: read/write data_dir.
  - 2 irq_mask: read/write.
  - 3 edge_capture: read; write 1 to clear each bit.
  - 4 outset: write-only, data_out |= wd. Reads 0.
  - 5 outclear: write-only, data_out &= ~wd. Reads 0.
  - 6, 7: unmapped. Reads 0, writes ignored.
- A write occurs when chipselect && !write_n on a rising clk edge. Only writedata[WIDTH-1:0] is used.
- Read:
  - readdata is registered on every clk from the address mux, regardless of chipselect.
  - Data is valid one cycle after the address is presented.
  - Bits [31:WIDTH] always read 0.
- Edge detection, per bit:
  - rise = data_sync & ~data_prev
  - fall = ~data_sync & data_prev
  - event is selected by EDGE_TYPE (EDGE_TYPE=2 uses rise|fall).
- edge_capture update: next = (edge_capture & ~clr_mask) | event.
  - If an event and a write-1-to-clear hit the same bit in the same cycle, set wins and the bit stays 1.
  - Edges are captured on output-direction bits too, because the pad reads back the driven value.
- irq: registered, irq <= |(edge_capture & irq_mask). It deasserts one cycle after the cause clears.
- Direction change: takes effect on the cycle after the write. The pin's input value then follows after SYNC_STAGES cycles.
- Reset mid-operation: all state returns to reset values immediately. No pending edge survives reset.
- The first edge after reset is judged against data_prev=0. A pin held high through reset therefore produces one rising event once its synchroniser fills.

Optional Feature:
- Macro: NIOS_SD_LOADER_BIDIR_PIO_SETCLR_EN
- Defined: addresses 4 and 5 act as outset and outclear as described above.
- Undefined:
  - Addresses 4 and 5 are unmapped: writes are ignored and reads return 0.
  - The set/clear logic is not synthesised.
  - data_out changes only through address 0.

Test Plan:
- Reset, then read addresses 0-7 with pins floating/pulled 0 and RESET_DIR=0 -> all reads 0, irq=0, bidir_port all Z.
- WIDTH=4: write dir=0xF, data=0xA -> bidir_port=4'b1010 on the cycle after the write. Read addr 0 -> 0xA after SYNC_STAGES+1 cycles.
- With the SETCLR macro defined: write data=0x3, outset 0x4, outclear 0x1 -> data_out=0x6 and pins=0x6.
- EDGE_TYPE=0, dir=0, mask=0x1: drive pin0 0->1 -> edge_capture=0x1 after SYNC_STAGES+1 cycles, irq=1 one cycle later. Write 0x1 to addr 3 -> edge_capture=0, irq=0 next cycle.
- Same setup: pin0 rises in the same cycle as a clear write to bit 0 -> edge_capture bit 0 stays 1 and irq stays 1.
- EDGE_TYPE=2, mask=0x0: toggle pin1 twice -> edge_capture=0x2 and irq stays 0. Then write mask=0x2 -> irq=1 on the next cycle.
